// File: rtl/pipe_ctrl.sv
// Central pipeline controller: stall-vector merge, exception flush/redirect and mem-stall watchdog.
// Define PIPE_CTRL_PERF_EN to build the stall_cycles / flush_count performance counters.
module pipe_ctrl #(
  parameter logic [31:0] EXC_VECTOR = 32'h00000020,
  parameter int unsigned WDT_LIMIT  = 16,
  parameter int unsigned WDT_W      = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stallreq_from_if,
  input  logic        stallreq_from_id,
  input  logic        stallreq_from_ex,
  input  logic        stallreq_from_mem,
  input  logic [31:0] excepttype_i,
  input  logic [31:0] cp0_epc_i,
  output logic [5:0]  stall,
  output logic        flush,
  output logic [31:0] new_pc,
  output logic        wdt_timeout,
  output logic [31:0] stall_cycles,
  output logic [31:0] flush_count
);

  typedef enum logic [1:0] {
    RUN        = 2'd0,
    WDT_FLUSH  = 2'd1,
    POST_FLUSH = 2'd2
  } state_e;

  localparam logic [WDT_W-1:0] WDT_MAX   = WDT_W'(WDT_LIMIT - 1);
  localparam logic [31:0]      ERET_CODE = 32'h0000000e;

  state_e           state_q, state_d;
  logic [WDT_W-1:0] wdt_cnt_q, wdt_cnt_d;
  logic [5:0]       req_vec;

  always_comb begin
    if (stallreq_from_mem)                         req_vec = 6'b011111;
    else if (stallreq_from_ex)                     req_vec = 6'b001111;
    else if (stallreq_from_id || stallreq_from_if) req_vec = 6'b000111;
    else                                           req_vec = 6'b000000;
  end

  always_comb begin
    state_d     = state_q;
    wdt_cnt_d   = wdt_cnt_q;
    stall       = '0;
    flush       = 1'b0;
    new_pc      = '0;
    wdt_timeout = 1'b0;

    case (state_q)
      RUN: begin
        if (excepttype_i != '0) begin
          flush     = 1'b1;
          new_pc    = (excepttype_i == ERET_CODE) ? cp0_epc_i : EXC_VECTOR;
          wdt_cnt_d = '0;
          state_d   = POST_FLUSH;
        end else begin
          stall = req_vec;
          if (stallreq_from_mem) begin
            // Counter holds at its threshold; the flush state clears it.
            if (wdt_cnt_q == WDT_MAX) state_d   = WDT_FLUSH;
            else                      wdt_cnt_d = wdt_cnt_q + WDT_W'(1);
          end else begin
            wdt_cnt_d = '0;
          end
        end
      end
      WDT_FLUSH: begin
        flush       = 1'b1;
        new_pc      = EXC_VECTOR;
        wdt_timeout = 1'b1;
        wdt_cnt_d   = '0;
        state_d     = POST_FLUSH;
      end
      POST_FLUSH: begin
        stall     = req_vec;
        wdt_cnt_d = '0;
        state_d   = RUN;
      end
      default: begin
        wdt_cnt_d = '0;
        state_d   = RUN;
      end
    endcase

    // Reset masks the combinational outputs as well as the state update.
    if (rst) begin
      state_d     = RUN;
      wdt_cnt_d   = '0;
      stall       = '0;
      flush       = 1'b0;
      new_pc      = '0;
      wdt_timeout = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    state_q   <= state_d;
    wdt_cnt_q <= wdt_cnt_d;
  end

`ifdef PIPE_CTRL_PERF_EN
  logic [31:0] stall_cycles_q, stall_cycles_d;
  logic [31:0] flush_count_q, flush_count_d;

  always_comb begin
    stall_cycles_d = stall_cycles_q;
    flush_count_d  = flush_count_q;
    if (rst) begin
      stall_cycles_d = '0;
      flush_count_d  = '0;
    end else begin
      if (stall[0]) stall_cycles_d = stall_cycles_q + 32'd1;
      if (flush)    flush_count_d  = flush_count_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    stall_cycles_q <= stall_cycles_d;
    flush_count_q  <= flush_count_d;
  end

  assign stall_cycles = stall_cycles_q;
  assign flush_count  = flush_count_q;
`else
  assign stall_cycles = '0;
  assign flush_count  = '0;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl (WDT_LIMIT=4): expectations queued per step, popped and checked mid-cycle.
module tb_pipe_ctrl;

  logic        clk;
  logic        rst;
  logic        stallreq_from_if, stallreq_from_id, stallreq_from_ex, stallreq_from_mem;
  logic [31:0] excepttype_i, cp0_epc_i;
  logic [5:0]  stall;
  logic        flush;
  logic [31:0] new_pc;
  logic        wdt_timeout;
  logic [31:0] stall_cycles, flush_count;

  localparam logic [5:0] S_MEM = 6'b011111;
  localparam logic [5:0] S_EX  = 6'b001111;
  localparam logic [5:0] S_ID  = 6'b000111;
  localparam logic [5:0] S_IF  = 6'b000111;
  localparam logic [3:0] R_MEM = 4'b1000;

  typedef struct {
    string       tag;
    logic [5:0]  stall;
    logic        flush;
    logic [31:0] new_pc;
    logic        wdt;
    logic        rst;
  } exp_t;

  exp_t        sb[$];
  int          checks   = 0;
  int          failures = 0;
  logic [31:0] m_stall  = '0;
  logic [31:0] m_flush  = '0;

  pipe_ctrl #(
    .EXC_VECTOR(32'h00000020),
    .WDT_LIMIT (4),
    .WDT_W     (16)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .stallreq_from_if (stallreq_from_if),
    .stallreq_from_id (stallreq_from_id),
    .stallreq_from_ex (stallreq_from_ex),
    .stallreq_from_mem(stallreq_from_mem),
    .excepttype_i     (excepttype_i),
    .cp0_epc_i        (cp0_epc_i),
    .stall            (stall),
    .flush            (flush),
    .new_pc           (new_pc),
    .wdt_timeout      (wdt_timeout),
    .stall_cycles     (stall_cycles),
    .flush_count      (flush_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout checks=%0d", checks);
    $fatal(1, "bench timeout");
  end

  // req = {mem, ex, id, if}
  task automatic step(input string tag, input logic r, input logic [3:0] req,
                      input logic [31:0] exc, input logic [31:0] epc,
                      input logic [5:0] e_stall, input logic e_flush,
                      input logic [31:0] e_pc, input logic e_wdt);
    exp_t e;
    rst = r;
    {stallreq_from_mem, stallreq_from_ex, stallreq_from_id, stallreq_from_if} = req;
    excepttype_i = exc;
    cp0_epc_i    = epc;
    sb.push_back('{tag, e_stall, e_flush, e_pc, e_wdt, r});
    @(negedge clk);
    e = sb.pop_front();
    checks++;
    assert (stall === e.stall) else begin
      failures++;
      $error("FAIL %s.stall actual=%b required=%b", e.tag, stall, e.stall);
    end
    checks++;
    assert (flush === e.flush) else begin
      failures++;
      $error("FAIL %s.flush actual=%b required=%b", e.tag, flush, e.flush);
    end
    checks++;
    assert (new_pc === e.new_pc) else begin
      failures++;
      $error("FAIL %s.new_pc actual=%h required=%h", e.tag, new_pc, e.new_pc);
    end
    checks++;
    assert (wdt_timeout === e.wdt) else begin
      failures++;
      $error("FAIL %s.wdt_timeout actual=%b required=%b", e.tag, wdt_timeout, e.wdt);
    end
    if (e.rst) begin
      m_stall = '0;
      m_flush = '0;
    end else begin
      m_stall = m_stall + 32'(e.stall[0]);
      m_flush = m_flush + 32'(e.flush);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic check_perf(input string tag);
    logic [31:0] exp_sc, exp_fc;
`ifdef PIPE_CTRL_PERF_EN
    exp_sc = m_stall;
    exp_fc = m_flush;
`else
    exp_sc = '0;
    exp_fc = '0;
`endif
    checks++;
    assert (stall_cycles === exp_sc) else begin
      failures++;
      $error("FAIL %s.stall_cycles actual=%0d required=%0d", tag, stall_cycles, exp_sc);
    end
    checks++;
    assert (flush_count === exp_fc) else begin
      failures++;
      $error("FAIL %s.flush_count actual=%0d required=%0d", tag, flush_count, exp_fc);
    end
  endtask

  initial begin
    rst = 1'b1;
    {stallreq_from_mem, stallreq_from_ex, stallreq_from_id, stallreq_from_if} = '0;
    excepttype_i = '0;
    cp0_epc_i    = '0;
    @(posedge clk);
    #1;

    // reset masks every request and exception
    step("rst0", 1'b1, 4'b1111, 32'h8, 32'h0, '0, 1'b0, '0, 1'b0);
    step("rst1", 1'b1, R_MEM,   32'h0, 32'h0, '0, 1'b0, '0, 1'b0);
    check_perf("perf_reset");
    step("idle0", 1'b0, 4'b0000, 32'h0, 32'h0, '0, 1'b0, '0, 1'b0);

    // priority
    step("pri_id_mem", 1'b0, 4'b1010, 32'h0, 32'h0, S_MEM, 1'b0, '0, 1'b0);
    step("pri_id",     1'b0, 4'b0010, 32'h0, 32'h0, S_ID,  1'b0, '0, 1'b0);
    step("pri_if",     1'b0, 4'b0001, 32'h0, 32'h0, S_IF,  1'b0, '0, 1'b0);
    step("pri_ex_id",  1'b0, 4'b0110, 32'h0, 32'h0, S_EX,  1'b0, '0, 1'b0);
    step("pri_ex_if",  1'b0, 4'b0101, 32'h0, 32'h0, S_EX,  1'b0, '0, 1'b0);
    step("pri_none",   1'b0, 4'b0000, 32'h0, 32'h0, '0,    1'b0, '0, 1'b0);

    // exception overrides stall; held excepttype ignored in the following cycle
    step("exc",      1'b0, 4'b0100, 32'h8, 32'h1234, '0,   1'b1, 32'h20, 1'b0);
    step("post_exc", 1'b0, 4'b0100, 32'h8, 32'h1234, S_EX, 1'b0, '0,     1'b0);
    step("run_exc",  1'b0, 4'b0000, 32'h0, 32'h0,    '0,   1'b0, '0,     1'b0);

    // eret redirects to EPC
    step("eret",      1'b0, R_MEM,   32'he, 32'h1234, '0, 1'b1, 32'h1234, 1'b0);
    step("post_eret", 1'b0, 4'b0000, 32'he, 32'h1234, '0, 1'b0, '0,       1'b0);
    step("idle1",     1'b0, 4'b0000, 32'h0, 32'h0,    '0, 1'b0, '0,       1'b0);

    // watchdog fires on the 5th consecutive mem-stall cycle, then restarts
    for (int i = 0; i < 4; i++)
      step("wdt_stall", 1'b0, R_MEM, 32'h0, 32'h0, S_MEM, 1'b0, '0, 1'b0);
    step("wdt_fire", 1'b0, R_MEM, 32'h8, 32'h0, '0,    1'b1, 32'h20, 1'b1);
    step("wdt_post", 1'b0, R_MEM, 32'h8, 32'h0, S_MEM, 1'b0, '0,     1'b0);
    for (int i = 0; i < 4; i++)
      step("wdt_restart", 1'b0, R_MEM, 32'h0, 32'h0, S_MEM, 1'b0, '0, 1'b0);
    step("wdt_fire2", 1'b0, R_MEM,   32'h0, 32'h0, '0, 1'b1, 32'h20, 1'b1);
    step("wdt_post2", 1'b0, 4'b0000, 32'h0, 32'h0, '0, 1'b0, '0,     1'b0);
    step("idle2",     1'b0, 4'b0000, 32'h0, 32'h0, '0, 1'b0, '0,     1'b0);

    // a one-cycle gap clears the counter
    for (int i = 0; i < 3; i++)
      step("clr_a", 1'b0, R_MEM, 32'h0, 32'h0, S_MEM, 1'b0, '0, 1'b0);
    step("clr_gap", 1'b0, 4'b0000, 32'h0, 32'h0, '0, 1'b0, '0, 1'b0);
    for (int i = 0; i < 3; i++)
      step("clr_b", 1'b0, R_MEM, 32'h0, 32'h0, S_MEM, 1'b0, '0, 1'b0);
    step("clr_end", 1'b0, 4'b0000, 32'h0, 32'h0, '0, 1'b0, '0, 1'b0);

    // exception at the watchdog threshold wins; watchdog does not fire
    for (int i = 0; i < 3; i++)
      step("exw_stall", 1'b0, R_MEM, 32'h0, 32'h0, S_MEM, 1'b0, '0, 1'b0);
    step("exw_exc",  1'b0, R_MEM,   32'h8, 32'h0, '0,    1'b1, 32'h20, 1'b0);
    step("exw_post", 1'b0, R_MEM,   32'h0, 32'h0, S_MEM, 1'b0, '0,     1'b0);
    step("exw_run",  1'b0, R_MEM,   32'h0, 32'h0, S_MEM, 1'b0, '0,     1'b0);
    step("exw_end",  1'b0, 4'b0000, 32'h0, 32'h0, '0,    1'b0, '0,     1'b0);
    check_perf("perf_mid");

    // reset during the watchdog flush cycle
    for (int i = 0; i < 4; i++)
      step("rwf_stall", 1'b0, R_MEM, 32'h0, 32'h0, S_MEM, 1'b0, '0, 1'b0);
    step("rwf_rst", 1'b1, R_MEM, 32'h0, 32'h0, '0, 1'b0, '0, 1'b0);
    check_perf("perf_after_rst");
    step("rwf_after", 1'b0, 4'b0000, 32'h0, 32'h0, '0, 1'b0, '0, 1'b0);

    // a little more traffic for the performance counters
    step("tail_mem", 1'b0, R_MEM,   32'h0, 32'h0, S_MEM, 1'b0, '0,     1'b0);
    step("tail_id",  1'b0, 4'b0010, 32'h0, 32'h0, S_ID,  1'b0, '0,     1'b0);
    step("tail_exc", 1'b0, 4'b0000, 32'h4, 32'h0, '0,    1'b1, 32'h20, 1'b0);
    step("tail_end", 1'b0, 4'b0000, 32'h0, 32'h0, '0,    1'b0, '0,     1'b0);
    check_perf("perf_end");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pipe_ctrl.md
Name: pipe_ctrl

Overview:
- Central pipeline controller for the 6-stage core (pc, if, id, ex, mem, wb).
- Merges per-stage stall requests into the 6-bit stall vector consumed by every stage register.
- Turns exceptions reported by the mem stage into a one-cycle flush plus redirect PC.
- Runs a memory-stall watchdog that forces a recovery flush when the mem stage hangs on the bus.

Parameters:
- EXC_VECTOR, 32'h00000020, redirect address for all exceptions except eret.
- WDT_LIMIT, 16, consecutive mem-stall cycles before watchdog fires; legal range 2..65535.
- WDT_W, 16, width of the watchdog counter.

Ports:
- clk  in  1  clock
- rst  in  1  reset
- stallreq_from_if  in  1  instruction-bus wait
- stallreq_from_id  in  1  load-use hazard
- stallreq_from_ex  in  1  div / madd / msub multi-cycle busy
- stallreq_from_mem  in  1  data-bus wait
- excepttype_i  in  32  exception code from mem stage; 0 = none
- cp0_epc_i  in  32  EPC value forwarded from CP0
- stall  out  6  bit0 pc … bit5 wb; 1 = hold
- flush  out  1  clear all stage registers this edge
- new_pc  out  32  redirect target, valid when flush=1
- wdt_timeout  out  1  one-cycle pulse, watchdog fired (to CP0 cause logic)
- stall_cycles  out  32  perf counter (optional feature)
- flush_count  out  32  perf counter (optional feature)

Behaviour:
- Interface: reset rst, synchronous, active-high; clock clk.
- Reset: state=RUN, watchdog counter=0, wdt_timeout=0, perf counters=0. While rst=1: stall=0, flush=0, new_pc=0.
- stall, flush and new_pc are combinational from the inputs and the current state; there is zero latency from request to stall.
- Stall priority, highest first:
  - mem → 6'b011111
  - ex → 6'b001111
  - id → 6'b000111
  - if → 6'b000111
  - none → 6'b000000
- State RUN:
  - If excepttype_i≠0: flush=1, stall=0 (flush overrides every stall request).
    - new_pc=cp0_epc_i when excepttype_i==32'h0000000e (eret); otherwise new_pc=EXC_VECTOR.
    - Next state POST_FLUSH.
  - Else if the watchdog counter == WDT_LIMIT-1 and stallreq_from_mem=1: next state WDT_FLUSH. The stall output is normal this cycle.
  - Else: flush=0, new_pc=0.
- State WDT_FLUSH (one cycle):
  - flush=1, new_pc=EXC_VECTOR, wdt_timeout=1, stall=0.
  - Requests and excepttype_i are ignored. Next state POST_FLUSH.
- State POST_FLUSH (one cycle):
  - excepttype_i is ignored (the flushed pipeline holds bubbles).
  - Stall requests are honoured normally; flush=0. Next state RUN.
- Watchdog counter:
  - Increments each cycle stallreq_from_mem=1 in RUN; saturates at WDT_LIMIT-1.
  - Clears to 0 when stallreq_from_mem=0, on any flush cycle, and in POST_FLUSH.
- Simultaneous exception and watchdog threshold in RUN: the exception wins. The counter clears and the state goes to POST_FLUSH; the watchdog does not fire.
- Stall requests asserted during a flush cycle are dropped for that cycle only. Requesters hold their request, so it is seen again next cycle.
- rst asserted in any state returns to RUN on the next edge; no pending flush survives reset.

Optional Feature:
- Macro PIPE_CTRL_PERF_EN.
- Defined:
  - stall_cycles increments each cycle stall[0]=1.
  - flush_count increments each cycle flush=1.
  - Both are 32-bit, wrap at 2^32, and clear on rst.
- Undefined: both outputs tie to 32'h0 and no counter flops are built.

Test Plan:
- Priority: stallreq_from_id=1 and stallreq_from_mem=1 in the same cycle → stall=6'b011111. Drop mem → stall=6'b000111 the same cycle.
- Exception: excepttype_i=32'h00000008 with stallreq_from_ex=1 → that cycle flush=1, stall=0, new_pc=32'h00000020. Next cycle excepttype_i=8 still high → flush=0 (POST_FLUSH).
- eret: cp0_epc_i=32'h00001234, excepttype_i=32'h0000000e → flush=1, new_pc=32'h00001234.
- Watchdog, WDT_LIMIT=4: stallreq_from_mem held high → stall=6'b011111 for 4 cycles. On the 5th cycle flush=1, wdt_timeout=1, new_pc=32'h00000020. Counter restarts afterwards.
- Watchdog clear: mem stall high for 3 cycles, low for 1, high for 3 → no wdt_timeout.
- Reset mid-flush: assert rst during the WDT_FLUSH cycle → next cycle flush=0, wdt_timeout=0, stall=0. With PIPE_CTRL_PERF_EN defined, flush_count=0 after reset.
